sum_bcd_display: RTL and testbench



---
 rtl/sum_disp_pkg.sv | 41 ++++
 rtl/sum_bcd_display_if.sv | 12 +
 rtl/bin2bcd_seq.sv | 97 +++++++++
 rtl/sum_bcd_display.sv | 78 +++++++
 tb/tb_sum_bcd_display.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_disp_pkg.sv
// Shared constants, converter state type and segment decoder for the
// sum BCD display stage.
package sum_disp_pkg;

    // Segment patterns {a,b,c,d,e,f,g,dp}, active-high, dp always off
    localparam logic [7:0] SEG_0     = 8'b11111100;
    localparam logic [7:0] SEG_1     = 8'b01100000;
    localparam logic [7:0] SEG_2     = 8'b11011010;
    localparam logic [7:0] SEG_3     = 8'b11110010;
    localparam logic [7:0] SEG_4     = 8'b01100110;
    localparam logic [7:0] SEG_5     = 8'b10110110;
    localparam logic [7:0] SEG_6     = 8'b10111110;
    localparam logic [7:0] SEG_7     = 8'b11100000;
    localparam logic [7:0] SEG_8     = 8'b11111110;
    localparam logic [7:0] SEG_9     = 8'b11110110;
    localparam logic [7:0] SEG_BLANK = 8'b00000000;

    localparam logic [1:0] DIG_ONES = 2'b10;
    localparam logic [1:0] DIG_TENS = 2'b01;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sum_bcd_display_if.sv
// Value input and display outputs of the sum BCD display stage.
interface sum_bcd_display_if #(
    parameter int unsigned VALUE_W = 5
);
    logic [VALUE_W-1:0] value;
    logic               busy;
    logic [7:0]         digit_seg;
    logic [1:0]         digit_con;

    modport master (output value, input busy, input digit_seg, input digit_con);
    modport slave  (input value, output busy, output digit_seg, output digit_con);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to two-digit BCD converter; ones/tens
// hold the last completed result.
module bin2bcd_seq
    import sum_disp_pkg::*;
#(
    parameter int unsigned VALUE_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [3:0]         ones,
    output logic [3:0]         tens
);

    localparam int unsigned    CNT_W    = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(VALUE_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    conv_state_e        state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [7:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [3:0]         ones_q, ones_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         adj_lo, adj_hi;

    assign adj_lo = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    assign adj_hi = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = 8'd0;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Adjust first, then shift the MSB of the binary word into the BCD LSB
                bcd_d = {adj_hi[2:0], adj_lo, bin_q[VALUE_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ones_d  = bcd_q[3:0];
                tens_d  = bcd_q[7:4];
                busy_d  = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= 8'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
        end
    end

    assign busy = busy_q;
    assign ones = ones_q;
    assign tens = tens_q;

endmodule

// File: rtl/sum_bcd_display.sv
// Converts the adder's binary sum to BCD on change and scans the two digits
// onto a common-segment 7-segment display.
module sum_bcd_display
    import sum_disp_pkg::*;
#(
    parameter int unsigned VALUE_W       = 5,
    parameter int unsigned SCAN_DIV_BITS = 11,
    parameter bit          BLANK_LZ      = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_bcd_display_if.slave  bus
);

    localparam logic [SCAN_DIV_BITS-1:0] PRESC_ONE = SCAN_DIV_BITS'(1);

    logic                     conv_busy, conv_done, start;
    logic [3:0]               ones, tens, digit;
    logic [VALUE_W-1:0]       cap_q, last_q;
    logic [SCAN_DIV_BITS-1:0] presc_q;
    logic                     sel_q, sel_d;
    logic [7:0]               seg_q, seg_d;
    logic [1:0]               con_q, con_d;

    // Converter is idle exactly when busy is low, so no state peek is needed
    assign start = !conv_busy && (bus.value != last_q);

    bin2bcd_seq #(
        .VALUE_W(VALUE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bus.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .ones  (ones),
        .tens  (tens)
    );

    // Segments and enable are both derived from the next select so they switch together
    always_comb begin
        sel_d = (&presc_q) ? ~sel_q : sel_q;
        digit = sel_d ? tens : ones;
        con_d = sel_d ? DIG_TENS : DIG_ONES;
        seg_d = seg_decode(digit);
        if (BLANK_LZ && sel_d && (tens == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q   <= '0;
            last_q  <= '0;
            presc_q <= '0;
            sel_q   <= 1'b0;
            seg_q   <= SEG_0;
            con_q   <= DIG_ONES;
        end else begin
            if (start) begin
                cap_q <= bus.value;
            end
            if (conv_done) begin
                last_q <= cap_q;
            end
            presc_q <= presc_q + PRESC_ONE;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            con_q   <= con_d;
        end
    end

    assign bus.busy      = conv_busy;
    assign bus.digit_seg = seg_q;
    assign bus.digit_con = con_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench: conversion latency, busy window, digit scan, input change
// mid-conversion, asynchronous reset and leading-zero blanking.
module tb_sum_bcd_display;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    sum_bcd_display_if #(.VALUE_W(5)) bus ();
    sum_bcd_display_if #(.VALUE_W(5)) bus2 ();

    sum_bcd_display #(
        .VALUE_W       (5),
        .SCAN_DIV_BITS (11),
        .BLANK_LZ      (1'b0)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sum_bcd_display #(
        .VALUE_W       (5),
        .SCAN_DIV_BITS (3),
        .BLANK_LZ      (1'b1)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    task automatic wait_con(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (bus.digit_con === want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        rst2_n     = 1'b0;
        bus.value  = 5'd0;
        bus2.value = 5'd7;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.digit_con !== 2'b10) $display("FAIL reset_con: got %b want 10", bus.digit_con);
        else n_pass++;
        n_checks++;
        if (bus.digit_seg !== 8'b11111100)
            $display("FAIL reset_seg: got %b want 11111100", bus.digit_seg);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        int bad_busy = 0;
        for (int k = 1; k <= 4096; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.digit_seg !== 8'b11111100) bad_busy++;
            if (k == 2047) begin
                n_checks++;
                if (bus.digit_con !== 2'b10)
                    $display("FAIL scan_before_toggle: got %b want 10", bus.digit_con);
                else n_pass++;
            end
            if (k == 2048) begin
                n_checks++;
                if (bus.digit_con !== 2'b01)
                    $display("FAIL scan_first_toggle: got %b want 01", bus.digit_con);
                else n_pass++;
            end
            if (k == 4096) begin
                n_checks++;
                if (bus.digit_con !== 2'b10)
                    $display("FAIL scan_second_toggle: got %b want 10", bus.digit_con);
                else n_pass++;
            end
        end
        n_checks++;
        if (bad_busy != 0) $display("FAIL idle_quiet: got %0d bad cycles want 0", bad_busy);
        else n_pass++;
    endtask

    task automatic test_convert_13();
        int  bad_busy = 0;
        bit  ok;
        logic [7:0] exp;
        bus.value = 5'd13;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (bus.busy !== (k <= 5 ? 1'b1 : 1'b0)) bad_busy++;
            if (k == 6) begin
                n_checks++;
                if (bus.digit_seg !== 8'b11111100)
                    $display("FAIL c13_seg_early: got %b want 11111100", bus.digit_seg);
                else n_pass++;
            end
            if (k == 7) begin
                exp = (bus.digit_con === 2'b10) ? 8'b11110010 : 8'b01100000;
                n_checks++;
                if (bus.digit_seg !== exp)
                    $display("FAIL c13_seg_latency: got %b want %b", bus.digit_seg, exp);
                else n_pass++;
            end
        end
        n_checks++;
        if (bad_busy != 0) $display("FAIL c13_busy_window: got %0d bad cycles want 0", bad_busy);
        else n_pass++;
        wait_con(2'b10, ok);
        n_checks++;
        if (!ok || bus.digit_seg !== 8'b11110010)
            $display("FAIL c13_ones: got %b want 11110010", bus.digit_seg);
        else n_pass++;
        wait_con(2'b01, ok);
        n_checks++;
        if (!ok || bus.digit_seg !== 8'b01100000)
            $display("FAIL c13_tens: got %b want 01100000", bus.digit_seg);
        else n_pass++;
    endtask

    task automatic test_max_31();
        bit ok;
        bus.value = 5'd31;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL c31_busy: got %b want 0", bus.busy);
        else n_pass++;
        wait_con(2'b10, ok);
        n_checks++;
        if (!ok || bus.digit_seg !== 8'b01100000)
            $display("FAIL c31_ones: got %b want 01100000", bus.digit_seg);
        else n_pass++;
        wait_con(2'b01, ok);
        n_checks++;
        if (!ok || bus.digit_seg !== 8'b11110010)
            $display("FAIL c31_tens: got %b want 11110010", bus.digit_seg);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp;
        bus.value = 5'd9;
        repeat (10) @(negedge clk);
        bus.value = 5'd22;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) bus.value = 5'd5;
            if (k == 6) begin
                n_checks++;
                if (bus.busy !== 1'b0) $display("FAIL b2b_busy_gap: got %b want 0", bus.busy);
                else n_pass++;
            end
            if (k == 7) begin
                n_checks++;
                if (bus.busy !== 1'b1) $display("FAIL b2b_restart: got %b want 1", bus.busy);
                else n_pass++;
                n_checks++;
                if (bus.digit_seg !== 8'b11011010)
                    $display("FAIL b2b_show22: got %b want 11011010", bus.digit_seg);
                else n_pass++;
            end
            if (k == 13) begin
                n_checks++;
                if (bus.busy !== 1'b0) $display("FAIL b2b_second_done: got %b want 0", bus.busy);
                else n_pass++;
            end
            if (k == 14) begin
                exp = (bus.digit_con === 2'b10) ? 8'b10110110 : 8'b11111100;
                n_checks++;
                if (bus.digit_seg !== exp)
                    $display("FAIL b2b_show5: got %b want %b", bus.digit_seg, exp);
                else n_pass++;
            end
        end
        wait_con(2'b10, ok);
        n_checks++;
        if (!ok || bus.digit_seg !== 8'b10110110)
            $display("FAIL b2b_ones5: got %b want 10110110", bus.digit_seg);
        else n_pass++;
        wait_con(2'b01, ok);
        n_checks++;
        if (!ok || bus.digit_seg !== 8'b11111100)
            $display("FAIL b2b_tens5: got %b want 11111100", bus.digit_seg);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.value = 5'd0;
        repeat (10) @(negedge clk);
        bus.value = 5'd25;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.digit_con !== 2'b10) $display("FAIL rst_mid_con: got %b want 10", bus.digit_con);
        else n_pass++;
        n_checks++;
        if (bus.digit_seg !== 8'b11111100)
            $display("FAIL rst_mid_seg: got %b want 11111100", bus.digit_seg);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                n_checks++;
                if (bus.busy !== 1'b1) $display("FAIL rst_rel_busy: got %b want 1", bus.busy);
                else n_pass++;
            end
            if (k == 7) begin
                n_checks++;
                if (bus.busy !== 1'b0) $display("FAIL rst_rel_done: got %b want 0", bus.busy);
                else n_pass++;
            end
            if (k == 8) begin
                n_checks++;
                if (bus.digit_con !== 2'b10 || bus.digit_seg !== 8'b10110110)
                    $display("FAIL rst_rel_show25: got %b/%b want 10/10110110",
                             bus.digit_con, bus.digit_seg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fast_scan_blank();
        logic [1:0] exp_con;
        logic [7:0] exp_seg;
        rst2_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_con = (((k / 8) % 2) == 1) ? 2'b01 : 2'b10;
            if (k < 8) exp_seg = 8'b11111100;
            else if (exp_con == 2'b01) exp_seg = 8'b00000000;
            else exp_seg = 8'b11100000;
            n_checks++;
            if (bus2.digit_con !== exp_con || bus2.digit_seg !== exp_seg)
                $display("FAIL fast_scan_k%0d: got %b/%b want %b/%b", k,
                         bus2.digit_con, bus2.digit_seg, exp_con, exp_seg);
            else n_pass++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_scan();
        test_convert_13();
        test_max_31();
        test_back_to_back();
        test_reset_mid();
        test_fast_scan_blank();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
